// File: rtl/m_proc12_pkg.sv
// Shared encodings, pipe-register layouts and helpers for the m_proc12 core.
package m_proc12_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h11;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // Operand source selects
  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_EXME = 2'd1;
  localparam logic [1:0] FWD_MEWB = 2'd2;

  // Internal operation after decode; A_NOP (0) is also the bubble op
  typedef enum logic [3:0] {
    A_NOP, A_ADD, A_SUB, A_AND, A_OR, A_SLT,
    A_ADDI, A_LW, A_SW, A_BEQ, A_BNE, A_HALT
  } op_e;

  typedef struct packed {
    logic        valid;
    logic        w;
    logic        we;
    op_e         op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        valid;
    logic        w;
    logic        we;
    op_e         op;
    logic [4:0]  rd2;
    logic [31:0] res;
    logic [31:0] sdata;
  } exme_t;

  typedef struct packed {
    logic        valid;
    logic        w;
    op_e         op;
    logic [4:0]  rd2;
    logic [31:0] res;
  } mewb_t;

  localparam idex_t IDEX_BUBBLE = '0;
  localparam exme_t EXME_BUBBLE = '0;
  localparam mewb_t MEWB_BUBBLE = '0;

  // A producer matches a source only if it writes a real register
  function automatic logic hit(input logic w, input logic [4:0] rd, input logic [4:0] src);
    return w && (rd != 5'd0) && (rd == src);
  endfunction

  function automatic op_e decode(input logic [5:0] opc, input logic [5:0] fn);
    op_e o;
    o = A_NOP;
    case (opc)
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  o = A_ADD;
          FN_SUB:  o = A_SUB;
          FN_AND:  o = A_AND;
          FN_OR:   o = A_OR;
          FN_SLT:  o = A_SLT;
          default: o = A_NOP;
        endcase
      end
      OP_ADDI: o = A_ADDI;
      OP_LW:   o = A_LW;
      OP_SW:   o = A_SW;
      OP_BEQ:  o = A_BEQ;
      OP_BNE:  o = A_BNE;
      OP_HALT: o = A_HALT;
      default: o = A_NOP;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/m_proc12_hazard.sv
// Interlock and operand-select logic for the ID and EX stages.
module m_hazard import m_proc12_pkg::*; (
  input  logic       id_valid,
  input  logic       id_use_rt,
  input  logic       id_is_br,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       idex_w,
  input  logic       idex_lw,
  input  logic [4:0] idex_rd2,
  input  logic [4:0] idex_rs,
  input  logic [4:0] idex_rt,
  input  logic       exme_w,
  input  logic       exme_lw,
  input  logic [4:0] exme_rd2,
  input  logic       mewb_w,
  input  logic [4:0] mewb_rd2,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] fwd_br
);

  logic load_use, br_idex, br_exme;

  // Stall sources; the two branch terms are independent so a LW right before a branch costs two cycles
  always_comb begin
    load_use = idex_lw && (hit(idex_w, idex_rd2, id_rs) ||
                           (id_use_rt && hit(idex_w, idex_rd2, id_rt)));
    br_idex  = id_is_br && (hit(idex_w, idex_rd2, id_rs) || hit(idex_w, idex_rd2, id_rt));
    br_exme  = id_is_br && exme_lw &&
               (hit(exme_w, exme_rd2, id_rs) || hit(exme_w, exme_rd2, id_rt));
    stall    = id_valid && (load_use || br_idex || br_exme);
  end

  // EX operand selects: youngest producer wins
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (hit(exme_w, exme_rd2, idex_rs))      fwd_a = FWD_EXME;
    else if (hit(mewb_w, mewb_rd2, idex_rs)) fwd_a = FWD_MEWB;
    if (hit(exme_w, exme_rd2, idex_rt))      fwd_b = FWD_EXME;
    else if (hit(mewb_w, mewb_rd2, idex_rt)) fwd_b = FWD_MEWB;
  end

  // Branch comparator may take an ALU result from MEM; MEM-stage load data is not ready yet
  always_comb begin
    fwd_br[0] = !exme_lw && hit(exme_w, exme_rd2, id_rs);
    fwd_br[1] = !exme_lw && hit(exme_w, exme_rd2, id_rt);
  end

endmodule

// File: rtl/m_proc12_mem.sv
// Single-port word memory, synchronous read with enable (output holds when re=0).
// WR=0 builds a ROM whose contents are placed by the loading environment (image INIT).
module m_memory2 #(
  parameter int AW   = 12,
  parameter     INIT = "",
  parameter bit WR   = 1'b1
) (
  input  logic          w_clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(2**AW)-1];
  logic        unused_init;

  assign unused_init = ^INIT;

  // Registered read port
  always_ff @(posedge w_clk) begin
    if (re) rdata <= mem[addr];
  end

  if (WR) begin : g_wr
    // Write port
    always_ff @(posedge w_clk) begin
      if (we) mem[addr] <= wdata;
    end
  end else begin : g_rom
    logic unused_wr;
    assign unused_wr = ^{we, wdata};
  end

endmodule

// File: rtl/m_proc12_rf.sv
// 32x32 register file; $0 reads zero, a same-cycle write is visible on the read ports.
module m_regfile (
  input  logic        w_clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [0:31];

  // Write port, $0 dropped
  always_ff @(posedge w_clk) begin
    if (we && wa != 5'd0) regs[wa] <= wd;
  end

  // Write-through read ports
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : (we && wa == ra1) ? wd : regs[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/m_proc12.sv
// Five-stage MIPS-subset core with interlocks, optional delay slot, sticky halt and counters.
module m_proc12 import m_proc12_pkg::*; #(
  parameter int IMEM_AW    = 12,
  parameter int DMEM_AW    = 12,
  parameter     IMEM_INIT  = "",
  parameter bit DELAY_SLOT = 1'b1,
  parameter int ROUT_REG   = 30
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic [31:0] r_rout,
  output logic        r_halt,
  output logic [31:0] r_cycles,
  output logic [31:0] r_retired
);

  logic [31:0] r_pc, ifid_pc4, instr;
  logic        ifid_valid;
  idex_t       idex, id_next;
  exme_t       exme, ex_next;
  mewb_t       mewb, me_next;

  logic        stall;
  logic [1:0]  fwd_a, fwd_b, fwd_br;
  logic [31:0] rf_rd1, rf_rd2, wb_data, dmem_rdata;
  logic        rf_we, halt_wb, dmem_we;

  // ID decode fields
  logic [5:0]  id_opc, id_fn;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm, br_a, br_b, br_target;
  op_e         id_op;
  logic        id_use_rt, id_is_br, id_w, br_take;

  logic [31:0] ex_a, ex_b, alu;
  logic        unused_top;

  assign unused_top = ^instr[10:6];

  m_memory2 #(.AW(IMEM_AW), .INIT(IMEM_INIT), .WR(1'b0)) u_imem (
    .w_clk (w_clk),
    .re    (!stall && !r_halt),
    .we    (1'b0),
    .addr  (r_pc[IMEM_AW+1:2]),
    .wdata (32'd0),
    .rdata (instr)
  );

  m_memory2 #(.AW(DMEM_AW)) u_dmem (
    .w_clk (w_clk),
    .re    (exme.op == A_LW && !r_halt),
    .we    (dmem_we),
    .addr  (exme.res[DMEM_AW+1:2]),
    .wdata (exme.sdata),
    .rdata (dmem_rdata)
  );

  m_regfile u_rf (
    .w_clk (w_clk),
    .we    (rf_we),
    .wa    (mewb.rd2),
    .wd    (wb_data),
    .ra1   (id_rs),
    .ra2   (id_rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  m_hazard u_hz (
    .id_valid (ifid_valid),
    .id_use_rt(id_use_rt),
    .id_is_br (id_is_br),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .idex_w   (idex.w),
    .idex_lw  (idex.op == A_LW),
    .idex_rd2 (idex.rd2),
    .idex_rs  (idex.rs),
    .idex_rt  (idex.rt),
    .exme_w   (exme.w),
    .exme_lw  (exme.op == A_LW),
    .exme_rd2 (exme.rd2),
    .mewb_w   (mewb.w),
    .mewb_rd2 (mewb.rd2),
    .stall    (stall),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
    .fwd_br   (fwd_br)
  );

  // WB value and side-effect enables; the SW behind a retiring HALT or under reset never lands
  always_comb begin
    wb_data = (mewb.op == A_LW) ? dmem_rdata : mewb.res;
    halt_wb = mewb.valid && mewb.op == A_HALT;
    rf_we   = mewb.w && !r_halt;
    dmem_we = exme.we && !r_halt && !halt_wb && !w_rst;
  end

  // ID: decode, branch compare and next IdEx contents
  always_comb begin
    id_opc    = instr[31:26];
    id_rs     = instr[25:21];
    id_rt     = instr[20:16];
    id_rd     = instr[15:11];
    id_fn     = instr[5:0];
    id_imm    = {{16{instr[15]}}, instr[15:0]};
    id_op     = ifid_valid ? decode(id_opc, id_fn) : A_NOP;
    id_use_rt = id_opc == OP_RTYPE || id_opc == OP_SW || id_opc == OP_BEQ || id_opc == OP_BNE;
    id_is_br  = id_op == A_BEQ || id_op == A_BNE;
    id_w      = id_op inside {A_ADD, A_SUB, A_AND, A_OR, A_SLT, A_ADDI, A_LW};
    br_a      = fwd_br[0] ? exme.res : rf_rd1;
    br_b      = fwd_br[1] ? exme.res : rf_rd2;
    br_take   = id_is_br && !stall && ((id_op == A_BEQ) == (br_a == br_b));
    br_target = ifid_pc4 + {id_imm[29:0], 2'b00};
    id_next       = IDEX_BUBBLE;
    id_next.valid = ifid_valid;
    id_next.w     = id_w;
    id_next.we    = id_op == A_SW;
    id_next.op    = id_op;
    id_next.rs    = id_rs;
    id_next.rt    = id_rt;
    id_next.rd2   = !id_w ? 5'd0 : (id_opc == OP_RTYPE) ? id_rd : id_rt;
    id_next.a     = rf_rd1;
    id_next.b     = rf_rd2;
    id_next.imm   = id_imm;
  end

  // EX: forwarded operands and ALU
  always_comb begin
    ex_a = (fwd_a == FWD_EXME) ? exme.res : (fwd_a == FWD_MEWB) ? wb_data : idex.a;
    ex_b = (fwd_b == FWD_EXME) ? exme.res : (fwd_b == FWD_MEWB) ? wb_data : idex.b;
    case (idex.op)
      A_ADD:             alu = ex_a + ex_b;
      A_SUB:             alu = ex_a - ex_b;
      A_AND:             alu = ex_a & ex_b;
      A_OR:              alu = ex_a | ex_b;
      A_SLT:             alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
      A_ADDI, A_LW, A_SW: alu = ex_a + idex.imm;
      default:           alu = 32'd0;
    endcase
    ex_next       = EXME_BUBBLE;
    ex_next.valid = idex.valid;
    ex_next.w     = idex.w;
    ex_next.we    = idex.we;
    ex_next.op    = idex.op;
    ex_next.rd2   = idex.rd2;
    ex_next.res   = alu;
    ex_next.sdata = ex_b;
    me_next       = MEWB_BUBBLE;
    me_next.valid = exme.valid;
    me_next.w     = exme.w;
    me_next.op    = exme.op;
    me_next.rd2   = exme.rd2;
    me_next.res   = exme.res;
  end

  // PC and pipe registers; a stall holds PC/IfId and drops a bubble into IdEx
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_pc       <= 32'd0;
      ifid_valid <= 1'b0;
      ifid_pc4   <= 32'd0;
      idex       <= IDEX_BUBBLE;
      exme       <= EXME_BUBBLE;
      mewb       <= MEWB_BUBBLE;
    end else if (!r_halt) begin
      if (!stall) begin
        r_pc       <= br_take ? br_target : r_pc + 32'd4;
        ifid_valid <= !(br_take && DELAY_SLOT == 1'b0);
        ifid_pc4   <= r_pc + 32'd4;
        idex       <= id_next;
      end else begin
        idex       <= IDEX_BUBBLE;
      end
      exme <= ex_next;
      mewb <= me_next;
    end
  end

  // Halt flag, counters and the ROUT_REG mirror
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_halt    <= 1'b0;
      r_cycles  <= 32'd0;
      r_retired <= 32'd0;
      r_rout    <= 32'd0;
    end else if (!r_halt) begin
      r_cycles <= r_cycles + 32'd1;
      if (mewb.valid) r_retired <= r_retired + 32'd1;
      if (halt_wb)    r_halt    <= 1'b1;
      if (rf_we && mewb.rd2 != 5'd0 && mewb.rd2 == 5'(ROUT_REG)) r_rout <= wb_data;
    end
  end

endmodule

// File: tb/tb_m_proc12.sv
// Directed programs for m_proc12: forwarding, load-use, branch interlocks, delay slot, halt, reset.
module tb_m_proc12;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic [31:0] r_rout, r_cycles, r_retired;
  logic [31:0] r_rout0, r_cycles0, r_retired0;
  logic        r_halt, r_halt0;

  int checks = 0;
  int errors = 0;
  logic [31:0] prog [$];

  always #5 w_clk = ~w_clk;

  m_proc12 #(.IMEM_AW(8), .DMEM_AW(8), .DELAY_SLOT(1'b1)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .r_rout(r_rout), .r_halt(r_halt),
    .r_cycles(r_cycles), .r_retired(r_retired)
  );

  m_proc12 #(.IMEM_AW(8), .DMEM_AW(8), .DELAY_SLOT(1'b0)) dut0 (
    .w_clk(w_clk), .w_rst(w_rst), .r_rout(r_rout0), .r_halt(r_halt0),
    .r_cycles(r_cycles0), .r_retired(r_retired0)
  );

  function automatic logic [31:0] f_r(int rd, int rs, int rt, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] f_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] f_addi(int rt, int rs, int imm); return f_i(6'h08, rs, rt, imm); endfunction
  function automatic logic [31:0] f_lw(int rt, int imm, int rs);   return f_i(6'h23, rs, rt, imm); endfunction
  function automatic logic [31:0] f_sw(int rt, int imm, int rs);   return f_i(6'h2b, rs, rt, imm); endfunction
  function automatic logic [31:0] f_halt();                        return {6'h11, 26'd0}; endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load();
    for (int i = 0; i < 256; i++) begin
      dut.u_imem.mem[i]  = (i < prog.size()) ? prog[i] : 32'd0;
      dut0.u_imem.mem[i] = (i < prog.size()) ? prog[i] : 32'd0;
    end
  endtask

  // Load while held in reset; returns on the negedge after the reset edge
  task automatic start();
    w_rst = 1'b1;
    load();
    @(negedge w_clk);
    w_rst = 1'b0;
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!(r_halt && r_halt0) && n < 400) begin
      @(negedge w_clk);
      n++;
    end
    check("halt_reached", {31'd0, r_halt && r_halt0}, 32'd1);
  endtask

  task automatic loop_prog();
    prog.delete();
    prog.push_back(f_addi(7, 0, 0));
    prog.push_back(f_addi(6, 0, 3));
    prog.push_back(f_addi(6, 6, -1));          // 8: loop
    prog.push_back(f_i(6'h05, 6, 0, -2));      // 12: bne $6,$0,loop
    prog.push_back(f_addi(7, 7, 1));           // 16: slot
    prog.push_back(f_halt());
  endtask

  initial begin
    repeat (2) @(negedge w_clk);

    // 1: back-to-back ALU forwarding, no stalls
    prog.delete();
    prog.push_back(f_addi(1, 0, 5));
    prog.push_back(f_r(2, 1, 1, 6'h20));
    prog.push_back(f_r(3, 2, 1, 6'h22));
    prog.push_back(f_halt());
    start();
    check("rst_rout", r_rout, 32'd0);
    check("rst_halt", {31'd0, r_halt}, 32'd0);
    check("rst_cycles", r_cycles, 32'd0);
    check("rst_retired", r_retired, 32'd0);
    check("rst_pc", dut.r_pc, 32'd0);
    wait_halt();
    check("t1_r2", dut.u_rf.regs[2], 32'd10);
    check("t1_r3", dut.u_rf.regs[3], 32'd5);
    check("t1_cycles", r_cycles, 32'd8);
    check("t1_retired", r_retired, 32'd4);

    // 2: store/load then load-use (one stall)
    prog.delete();
    prog.push_back(f_addi(1, 0, 5));
    prog.push_back(f_sw(1, 0, 0));
    prog.push_back(f_lw(4, 0, 0));
    prog.push_back(f_r(5, 4, 4, 6'h20));
    prog.push_back(f_halt());
    start();
    wait_halt();
    check("t2_r5", dut.u_rf.regs[5], 32'd10);
    check("t2_cycles", r_cycles, 32'd10);
    check("t2_retired", r_retired, 32'd5);

    // 3: counted loop, delay slot on/off
    loop_prog();
    start();
    wait_halt();
    check("t3_r7_ds1", dut.u_rf.regs[7], 32'd3);
    check("t3_r7_ds0", dut0.u_rf.regs[7], 32'd1);
    check("t3_cycles_ds1", r_cycles, 32'd19);
    check("t3_retired_ds1", r_retired, 32'd12);
    check("t3_cycles_ds0", r_cycles0, 32'd19);
    check("t3_retired_ds0", r_retired0, 32'd10);

    // 4: lw feeding beq (two stalls), taken target, signed slt
    prog.delete();
    prog.push_back(f_addi(14, 0, 0));
    prog.push_back(f_addi(9, 0, 7));
    prog.push_back(f_sw(9, 4, 0));
    prog.push_back(f_lw(8, 4, 0));
    prog.push_back(f_i(6'h04, 8, 9, 2));       // 16: beq -> 28
    prog.push_back(f_addi(13, 0, 1));          // 20: slot
    prog.push_back(f_addi(14, 0, 9));          // 24: skipped
    prog.push_back(f_addi(11, 0, -1));         // 28
    prog.push_back(f_addi(12, 0, 1));
    prog.push_back(f_r(10, 11, 12, 6'h2a));
    prog.push_back(f_halt());
    start();
    wait_halt();
    check("t4_r10_slt", dut.u_rf.regs[10], 32'd1);
    check("t4_r14_skip", dut.u_rf.regs[14], 32'd0);
    check("t4_r13_slot", dut.u_rf.regs[13], 32'd1);
    check("t4_r8", dut.u_rf.regs[8], 32'd7);
    check("t4_cycles", r_cycles, 32'd16);
    check("t4_retired", r_retired, 32'd10);

    // 5: r_rout mirror, halt freezes stores, writebacks and counters
    prog.delete();
    prog.push_back(f_addi(1, 0, 16'h5ffa));
    for (int i = 0; i < 12; i++) prog.push_back(f_r(1, 1, 1, 6'h20));
    prog.push_back(f_addi(2, 0, 16'h1234));
    prog.push_back(f_sw(2, 8, 0));
    prog.push_back(f_r(30, 0, 1, 6'h20));
    prog.push_back(f_halt());
    prog.push_back(f_sw(1, 8, 0));
    prog.push_back(f_addi(30, 0, 1));
    prog.push_back(f_addi(3, 0, 1));
    start();
    wait_halt();
    check("t5_rout", r_rout, 32'h05ffa000);
    check("t5_halt", {31'd0, r_halt}, 32'd1);
    check("t5_dmem", dut.u_dmem.mem[2], 32'h00001234);
    check("t5_r30", dut.u_rf.regs[30], 32'h05ffa000);
    check("t5_cycles", r_cycles, 32'd21);
    check("t5_retired", r_retired, 32'd17);
    repeat (6) @(negedge w_clk);
    check("t5_cycles_frozen", r_cycles, 32'd21);
    check("t5_retired_frozen", r_retired, 32'd17);
    check("t5_rout_frozen", r_rout, 32'h05ffa000);

    // 6: reset out of halt, then a one-cycle reset mid-loop
    loop_prog();
    start();
    check("t6_rst_halt", {31'd0, r_halt}, 32'd0);
    check("t6_rst_rout", r_rout, 32'd0);
    repeat (10) @(negedge w_clk);
    check("t6_running", {31'd0, r_halt}, 32'd0);
    w_rst = 1'b1;
    @(negedge w_clk);
    w_rst = 1'b0;
    check("t6_pc", dut.r_pc, 32'd0);
    check("t6_cycles", r_cycles, 32'd0);
    check("t6_retired", r_retired, 32'd0);
    check("t6_halt", {31'd0, r_halt}, 32'd0);
    wait_halt();
    check("t6_r7", dut.u_rf.regs[7], 32'd3);
    check("t6_cycles_rerun", r_cycles, 32'd19);
    check("t6_retired_rerun", r_retired, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
